// File: rtl/fp_special_pkg.sv
// rtl/fp_special_pkg.sv - operand classes and special-value constants for the FP multiply front end
package fp_special_pkg;

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_DENORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Constants are right-aligned in 64 bits; callers truncate to 1+exp_w+man_w.
  function automatic logic [63:0] qnan_const(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1)) | (64'd1 << (exp_w + man_w));
    return v;
  endfunction

  function automatic logic [63:0] inf_const(input int exp_w, input int man_w, input logic sign);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    if (sign) v = v | (64'd1 << (exp_w + man_w));
    return v;
  endfunction

endpackage

// File: rtl/fp_mult_special_stage_if.sv
// rtl/fp_mult_special_stage_if.sv - valid/ready beat bundle between issue, special stage and multiplier
interface fp_mult_special_stage_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [EXP_W+MAN_W:0]     a_in;
  logic [EXP_W+MAN_W:0]     b_in;
  logic [TAG_W-1:0]         tag_in;
  logic                     natlog_in;
  logic [EXP_W+MAN_W:0]     z_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W+MAN_W+1:0]   a_out;
  logic [EXP_W+MAN_W+1:0]   b_out;
  logic [EXP_W+MAN_W:0]     z_res;
  logic                     bypass;
  logic [TAG_W-1:0]         tag_out;
  logic [EXP_W+MAN_W:0]     z_out;
  logic [CNT_W-1:0]         special_cnt;
  logic                     cnt_clr;

  modport master (
    output in_valid, a_in, b_in, tag_in, natlog_in, z_in, out_ready, cnt_clr,
    input  in_ready, out_valid, a_out, b_out, z_res, bypass, tag_out, z_out, special_cnt
  );

  modport slave (
    input  in_valid, a_in, b_in, tag_in, natlog_in, z_in, out_ready, cnt_clr,
    output in_ready, out_valid, a_out, b_out, z_res, bypass, tag_out, z_out, special_cnt
  );
endinterface

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - classify a packed operand and unpack it with an explicit hidden bit
// Denormals are kept only when FP_SPECIAL_DENORM_EN is defined; otherwise flushed to signed zero.
module fp_classify
  import fp_special_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0]   op_i,
  output fp_class_e              cls_o,
  output logic [EXP_W+MAN_W+1:0] unp_o
);
  logic             sign;
  logic [EXP_W-1:0] expo;
  logic [MAN_W-1:0] frac;

  assign {sign, expo, frac} = op_i;

  always_comb begin
    cls_o = CLS_NORMAL;
    unp_o = {sign, expo, 1'b1, frac};
    if (expo == '1) begin
      cls_o = (frac != '0) ? CLS_NAN : CLS_INF;
      unp_o = {sign, expo, 1'b0, frac};
    end else if (expo == '0) begin
      cls_o = CLS_ZERO;
      unp_o = {sign, {(EXP_W+MAN_W+1){1'b0}}};
`ifdef FP_SPECIAL_DENORM_EN
      // Denormal exponent is 1-bias, expressed as biased exponent 1 with no hidden bit.
      if (frac != '0) begin
        cls_o = CLS_DENORM;
        unp_o = {sign, EXP_W'(1), 1'b0, frac};
      end
`endif
    end
  end
endmodule

// File: rtl/fp_mult_special_stage.sv
// rtl/fp_mult_special_stage.sv - FP multiply front end: special-case bypass, unpack, z adjust, 1-deep pipe
// Optional denormal support selected by FP_SPECIAL_DENORM_EN (see fp_classify).
module fp_mult_special_stage
  import fp_special_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  fp_mult_special_stage_if.slave io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int UW = W + 1;
  localparam logic [W-1:0] QNAN    = W'(qnan_const(EXP_W, MAN_W));
  localparam logic [W-1:0] INF_POS = W'(inf_const(EXP_W, MAN_W, 1'b0));

  fp_class_e         cls_a, cls_b;
  logic [UW-1:0]     unp_a, unp_b;
  logic              sign_d, accept;
  logic              bypass_d;
  logic [W-1:0]      z_res_d, z_d;

  logic              out_valid_q, bypass_q;
  logic [UW-1:0]     a_q, b_q;
  logic [W-1:0]      z_res_q, z_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  cnt_q;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.op_i(io.a_in), .cls_o(cls_a), .unp_o(unp_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.op_i(io.b_in), .cls_o(cls_b), .unp_o(unp_b));

  assign sign_d      = io.a_in[W-1] ^ io.b_in[W-1];
  assign io.in_ready = !out_valid_q || io.out_ready;
  assign accept      = io.in_valid && io.in_ready;

  always_comb begin
    bypass_d = 1'b1;
    z_res_d  = '0;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
      z_res_d = QNAN;
    end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      z_res_d = QNAN;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      z_res_d = INF_POS | {sign_d, {(W-1){1'b0}}};
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      z_res_d = {sign_d, {(W-1){1'b0}}};
    end else begin
      bypass_d = 1'b0;
    end
  end

  // Exponent increment wraps modulo 2^EXP_W on purpose; sign and fraction untouched.
  always_comb begin
    z_d = io.z_in;
    if (io.natlog_in) z_d[W-2:MAN_W] = io.z_in[W-2:MAN_W] + EXP_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bypass_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      z_res_q     <= '0;
      z_q         <= '0;
      tag_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      bypass_q    <= bypass_d;
      a_q         <= unp_a;
      b_q         <= unp_b;
      z_res_q     <= z_res_d;
      z_q         <= z_d;
      tag_q       <= io.tag_in;
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || io.cnt_clr) begin
      cnt_q <= '0;
    end else if (accept && bypass_d && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.bypass      = bypass_q;
  assign io.a_out       = a_q;
  assign io.b_out       = b_q;
  assign io.z_res       = z_res_q;
  assign io.z_out       = z_q;
  assign io.tag_out     = tag_q;
  assign io.special_cnt = cnt_q;
endmodule
